uart_parity_unit: RTL and testbench

Parametrised parity engine shared by the UART transmitter and receiver. It generates the transmit parity bit from a parallel data word in one clock. It also accumulates parity serially over received data bits under a bit strobe and checks the received parity bit, flagging errors. It supports even, odd, mark and space parity, plus a parity-disabled frame mode. It sits between the Tx/Rx FSMs and the frame configuration registers.

---
 rtl/uart_parity_unit.sv | 122 ++++++++++++
 tb/tb_uart_parity_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_unit.sv
// Parity engine shared by the UART Tx and Rx paths: one-cycle Tx parity generation
// and a strobe-driven serial Rx parity accumulator/checker.
module uart_parity_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAR_EN,
  input  logic [1:0]       PAR_MODE,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  output logic             par_bit,
  input  logic             rx_start,
  input  logic             bit_strobe,
  input  logic             rx_bit,
  output logic             rx_busy,
  output logic             par_chk_done,
  output logic             par_err
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_EVEN  = 2'b00,
    MODE_ODD   = 2'b01,
    MODE_MARK  = 2'b10,
    MODE_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } rx_state_t;

  function automatic logic par_of(input par_mode_t mode, input logic xor_sum);
    case (mode)
      MODE_EVEN: par_of = xor_sum;
      MODE_ODD:  par_of = ~xor_sum;
      MODE_MARK: par_of = 1'b1;
      default:   par_of = 1'b0;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      par_bit <= 1'b0;
    else if (Data_Valid && PAR_EN)
      par_bit <= par_of(par_mode_t'(PAR_MODE), ^P_DATA);
  end

  rx_state_t state, state_n;
  logic      cfg_en, cfg_en_n;
  par_mode_t cfg_mode, cfg_mode_n;
  logic      acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic      done_n, err_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      cfg_en       <= 1'b0;
      cfg_mode     <= MODE_EVEN;
      acc          <= 1'b0;
      cnt          <= '0;
      par_chk_done <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      state        <= state_n;
      cfg_en       <= cfg_en_n;
      cfg_mode     <= cfg_mode_n;
      acc          <= acc_n;
      cnt          <= cnt_n;
      par_chk_done <= done_n;
      par_err      <= err_n;
    end
  end

  // rx_start takes priority over any strobe, including one in the same cycle.
  always_comb begin
    state_n    = state;
    cfg_en_n   = cfg_en;
    cfg_mode_n = cfg_mode;
    acc_n      = acc;
    cnt_n      = cnt;
    done_n     = 1'b0;
    err_n      = par_err;
    if (rx_start) begin
      state_n    = DATA;
      cfg_en_n   = PAR_EN;
      cfg_mode_n = par_mode_t'(PAR_MODE);
      acc_n      = 1'b0;
      cnt_n      = '0;
    end else if (bit_strobe) begin
      case (state)
        DATA: begin
          acc_n = acc ^ rx_bit;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) begin
            if (cfg_en) begin
              state_n = PAR;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
              err_n   = 1'b0;
            end
          end
        end
        PAR: begin
          err_n   = (rx_bit != par_of(cfg_mode, acc));
          done_n  = 1'b1;
          state_n = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed-vector bench for uart_parity_unit: WIDTH=8 main instance plus
// WIDTH=5 and WIDTH=9 instances sharing the Rx stimulus.
module tb_uart_parity_unit;

  logic       CLK, RST, PAR_EN, Data_Valid, rx_start, bit_strobe, rx_bit;
  logic [1:0] PAR_MODE;
  logic [7:0] P8;
  logic [4:0] P5;
  logic [8:0] P9;
  logic par8, busy8, done8, err8;
  logic par5, busy5, done5, err5;
  logic par9, busy9, done9, err9;

  int n_vec = 0;
  int n_err = 0;
  int dc8 = 0, dc5 = 0, dc9 = 0;

  uart_parity_unit #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .P_DATA(P8),
    .Data_Valid(Data_Valid), .par_bit(par8), .rx_start(rx_start), .bit_strobe(bit_strobe),
    .rx_bit(rx_bit), .rx_busy(busy8), .par_chk_done(done8), .par_err(err8));

  uart_parity_unit #(.WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .P_DATA(P5),
    .Data_Valid(Data_Valid), .par_bit(par5), .rx_start(rx_start), .bit_strobe(bit_strobe),
    .rx_bit(rx_bit), .rx_busy(busy5), .par_chk_done(done5), .par_err(err5));

  uart_parity_unit #(.WIDTH(9)) dut9 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .P_DATA(P9),
    .Data_Valid(Data_Valid), .par_bit(par9), .rx_start(rx_start), .bit_strobe(bit_strobe),
    .rx_bit(rx_bit), .rx_busy(busy9), .par_chk_done(done9), .par_err(err9));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (done8) dc8++;
    if (done5) dc5++;
    if (done9) dc9++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      5:       return done5;
      9:       return done9;
      default: return done8;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      5:       return busy5;
      9:       return busy9;
      default: return busy8;
    endcase
  endfunction

  function automatic logic err_of(input int w);
    case (w)
      5:       return err5;
      9:       return err9;
      default: return err8;
    endcase
  endfunction

  function automatic int dcount(input int w);
    case (w)
      5:       return dc5;
      9:       return dc9;
      default: return dc8;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic b);
    bit_strobe = 1'b1;
    rx_bit     = b;
    tick();
    bit_strobe = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic start_frame(input logic en, input logic [1:0] mode, input logic collide);
    PAR_EN     = en;
    PAR_MODE   = mode;
    rx_start   = 1'b1;
    bit_strobe = collide;
    rx_bit     = collide;
    tick();
    rx_start   = 1'b0;
    bit_strobe = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic tx_load(input logic [7:0] d, input logic [1:0] mode);
    P8         = d;
    PAR_MODE   = mode;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    P8         = ~d;
  endtask

  // Full frame with 16-cycle strobe spacing; checks done timing on instance w.
  task automatic run_frame(input string tag, input int w, input logic en, input logic [1:0] mode,
                           input logic [8:0] data, input int nd, input logic pbit,
                           input logic exp_err, input int toggle_at, input logic collide);
    int d0;
    int nb;
    logic [9:0] bits;
    bits = '0;
    for (int i = 0; i < nd; i++) bits[i] = data[i];
    bits[nd] = pbit;
    nb = en ? nd + 1 : nd;
    d0 = dcount(w);
    start_frame(en, mode, collide);
    for (int i = 0; i < nb; i++) begin
      gap(15);
      if (i == toggle_at) PAR_EN = ~PAR_EN;
      if (i == nb - 1) begin
        check({tag, "_busy_pre"}, busy_of(w), 1);
        check({tag, "_done_pre"}, done_of(w), 0);
      end
      strobe(bits[i]);
    end
    check({tag, "_done"}, done_of(w), 1);
    check({tag, "_busy_post"}, busy_of(w), 0);
    check({tag, "_err"}, err_of(w), exp_err);
    tick();
    check({tag, "_done_pulse"}, done_of(w), 0);
    check({tag, "_done_count"}, dcount(w) - d0, 1);
    PAR_EN = 1'b1;
  endtask

  int d0;
  logic [1:0] tx_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    RST = 1'b0; PAR_EN = 1'b0; PAR_MODE = 2'b00; Data_Valid = 1'b0;
    rx_start = 1'b0; bit_strobe = 1'b0; rx_bit = 1'b0;
    P8 = '0; P5 = '0; P9 = '0;
    #12;
    check("rst_par_bit", par8, 0);
    check("rst_par_err", err8, 0);
    check("rst_done", done8, 0);
    check("rst_busy", busy8, 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    PAR_EN = 1'b1;
    for (int m = 0; m < 4; m++) begin
      tx_load(8'hA5, 2'(m));
      check("tx_a5", par8, tx_exp[m]);
      gap(10);
      check("tx_a5_hold", par8, tx_exp[m]);
    end
    P5 = 5'b10110;
    P9 = 9'h0A5;
    tx_load(8'hA4, 2'b00);
    check("tx_a4_even", par8, 1);
    check("tx_w5_even", par5, 1);
    check("tx_w9_even", par9, 0);
    gap(10);
    check("tx_a4_hold", par8, 1);
    PAR_EN = 1'b0;
    tx_load(8'hA5, 2'b00);
    check("tx_dis_hold", par8, 1);
    PAR_EN = 1'b1;

    run_frame("even_ok", 8, 1'b1, 2'b00, 9'h05B, 8, 1'b1, 1'b0, -1, 1'b0);
    run_frame("even_bad", 8, 1'b1, 2'b00, 9'h05B, 8, 1'b0, 1'b1, -1, 1'b0);
    gap(20);
    check("err_hold", err8, 1);
    start_frame(1'b1, 2'b00, 1'b0);
    check("err_kept_on_start", err8, 1);

    run_frame("nopar", 8, 1'b0, 2'b00, 9'h0FF, 8, 1'b0, 1'b0, 3, 1'b0);
    gap(15);
    strobe(1'b1);
    tick();
    check("nopar_extra_done", done8, 0);
    check("nopar_extra_busy", busy8, 0);

    d0 = dc8;
    start_frame(1'b1, 2'b01, 1'b0);
    strobe(1'b1); gap(2); strobe(1'b1); gap(2); strobe(1'b1); gap(2); strobe(1'b0); gap(2);
    start_frame(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      gap(3);
      strobe(1'b0);
    end
    gap(3);
    check("abort_busy_pre", busy8, 1);
    strobe(1'b1);
    check("abort_done", done8, 1);
    gap(3);
    check("abort_done_count", dc8 - d0, 1);
    check("abort_err", err8, 0);

    bit_strobe = 1'b1; rx_bit = 1'b1;
    tick();
    bit_strobe = 1'b0; rx_bit = 1'b0;
    check("idle_strobe_busy", busy8, 0);
    run_frame("collide", 8, 1'b1, 2'b00, 9'h001, 8, 1'b0, 1'b1, -1, 1'b1);

    d0 = dc8;
    start_frame(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      gap(2);
      strobe(1'b1);
    end
    check("pre_rst_busy", busy8, 1);
    check("pre_rst_par_bit", par8, 1);
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_par_bit", par8, 0);
    check("mid_rst_err", err8, 0);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(1'b1);
    gap(2);
    check("post_rst_busy", busy8, 0);
    check("post_rst_no_done", dc8 - d0, 0);

    run_frame("w5_bad", 5, 1'b1, 2'b00, 9'h016, 5, 1'b0, 1'b1, -1, 1'b0);
    run_frame("w5_ok", 5, 1'b1, 2'b00, 9'h016, 5, 1'b1, 1'b0, -1, 1'b0);
    run_frame("w9_ok", 9, 1'b1, 2'b01, 9'h1A5, 9, 1'b0, 1'b0, -1, 1'b0);
    run_frame("w9_bad", 9, 1'b1, 2'b01, 9'h1A5, 9, 1'b1, 1'b1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
